cache_mem_bridge: RTL and testbench

//  Downstream stage of cache_controller: turns its one-cycle read_en_mem / write_en_mem commands into

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and defaults used by the controller, data array and memory bridge.
package cache_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_WORD_WIDTH = 32;
   localparam int unsigned DEF_LINE_WORDS = 4;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      RD_REQ,
      RD_WAIT,
      DONE
   } mem_bridge_state_t;

   // Number of byte-offset bits inside one cache line.
   function automatic int unsigned line_offs(input int unsigned line_words,
                                             input int unsigned word_width);
      return $clog2(line_words) + $clog2(word_width / 8);
   endfunction

endpackage

// File: rtl/cache_mem_bridge.sv
// Converts single-cycle refill / write-back commands from the cache controller into
// word-wide bursts on the main-memory request/response bus.
module cache_mem_bridge
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             read_en_mem,
   input  logic                             write_en_mem,
   input  logic [ADDR_WIDTH-1:0]            miss_addr,
   input  logic [ADDR_WIDTH-1:0]            evict_addr,
   input  logic [LINE_WORDS*WORD_WIDTH-1:0] evict_line,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] refill_line,
   output logic                             ready_mem,
   output logic                             busy,
   output logic                             cmd_err,
   output logic                             mem_req_valid,
   input  logic                             mem_req_ready,
   output logic                             mem_req_we,
   output logic [ADDR_WIDTH-1:0]            mem_req_addr,
   output logic [WORD_WIDTH-1:0]            mem_req_wdata,
   input  logic                             mem_rsp_valid,
   input  logic [WORD_WIDTH-1:0]            mem_rsp_rdata
);

   localparam int unsigned CW    = $clog2(LINE_WORDS);
   localparam int unsigned BOFF  = $clog2(WORD_WIDTH / 8);
   localparam int unsigned OFFS  = line_offs(LINE_WORDS, WORD_WIDTH);
   localparam int unsigned TAG_W = ADDR_WIDTH - OFFS;
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

   mem_bridge_state_t     state, state_n;
   logic [CW-1:0]         wb_cnt, wb_cnt_n, rq_cnt, rq_cnt_n, rs_cnt, rs_cnt_n;
   logic                  pending_rd, pending_rd_n;
   logic [TAG_W-1:0]      wb_line, wb_line_n, rd_line, rd_line_n;
   logic [WORD_WIDTH-1:0] evict_q  [LINE_WORDS];
   logic [WORD_WIDTH-1:0] refill_q [LINE_WORDS];
   logic                  hs, wr_acc, rd_acc, drop, rsp_take;
   logic                  req_valid_n, req_we_n, ready_n, busy_n;
   logic [ADDR_WIDTH-1:0] req_addr_n;
   logic [WORD_WIDTH-1:0] req_wdata_n;
   logic                  unused_offs;

   // Line offsets of the command addresses are recomputed per beat, so the incoming bits are dropped.
   assign unused_offs = ^{miss_addr[OFFS-1:0], evict_addr[OFFS-1:0]};

   // Byte address of one beat within a line.
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_W-1:0] line,
                                                       input logic [CW-1:0]    beat);
      return ADDR_WIDTH'({line, beat}) << BOFF;
   endfunction

   // Command acceptance, burst sequencing and next values of the registered bus outputs.
   always_comb begin
      state_n      = state;
      wb_cnt_n     = wb_cnt;
      rq_cnt_n     = rq_cnt;
      rs_cnt_n     = rs_cnt;
      pending_rd_n = pending_rd;
      hs           = mem_req_valid & mem_req_ready;
      wr_acc       = write_en_mem && (state == IDLE);
      rd_acc       = read_en_mem && !pending_rd && ((state == IDLE) || (state == WB));
      drop         = (write_en_mem && !wr_acc) || (read_en_mem && !rd_acc);
      rsp_take     = mem_rsp_valid && ((state == RD_REQ) || (state == RD_WAIT));
      wb_line_n    = wr_acc ? evict_addr[ADDR_WIDTH-1:OFFS] : wb_line;
      rd_line_n    = rd_acc ? miss_addr[ADDR_WIDTH-1:OFFS] : rd_line;

      case (state)
         IDLE: begin
            if (wr_acc) begin
               state_n      = WB;
               pending_rd_n = rd_acc;
            end else if (rd_acc) begin
               state_n = RD_REQ;
            end
         end
         WB: begin
            pending_rd_n = pending_rd | rd_acc;
            if (hs) begin
               wb_cnt_n = wb_cnt + CW'(1);
               if (wb_cnt == LAST_BEAT) state_n = pending_rd_n ? RD_REQ : IDLE;
            end
         end
         RD_REQ: begin
            if (hs) begin
               rq_cnt_n = rq_cnt + CW'(1);
               if (rq_cnt == LAST_BEAT) state_n = RD_WAIT;
            end
            if (rsp_take && (rs_cnt == LAST_BEAT)) state_n = DONE;
         end
         RD_WAIT: begin
            if (rsp_take && (rs_cnt == LAST_BEAT)) state_n = DONE;
         end
         DONE: begin
            pending_rd_n = 1'b0;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (rsp_take) rs_cnt_n = rs_cnt + CW'(1);

      req_valid_n = (state_n == WB) || (state_n == RD_REQ);
      req_we_n    = (state_n == WB);
      ready_n     = (state_n == DONE);
      busy_n      = (state_n != IDLE) || pending_rd_n;
      req_addr_n  = '0;
      req_wdata_n = '0;
      if (state_n == WB) begin
         req_addr_n  = beat_addr(wb_line_n, wb_cnt_n);
         req_wdata_n = wr_acc ? evict_line[WORD_WIDTH-1:0] : evict_q[wb_cnt_n];
      end else if (state_n == RD_REQ) begin
         req_addr_n = beat_addr(rd_line_n, rq_cnt_n);
      end
   end

   // State, counters, command snapshots, refill buffer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wb_cnt        <= '0;
         rq_cnt        <= '0;
         rs_cnt        <= '0;
         pending_rd    <= 1'b0;
         wb_line       <= '0;
         rd_line       <= '0;
         cmd_err       <= 1'b0;
         ready_mem     <= 1'b0;
         busy          <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            evict_q[i]  <= '0;
            refill_q[i] <= '0;
         end
      end else begin
         state         <= state_n;
         wb_cnt        <= wb_cnt_n;
         rq_cnt        <= rq_cnt_n;
         rs_cnt        <= rs_cnt_n;
         pending_rd    <= pending_rd_n;
         wb_line       <= wb_line_n;
         rd_line       <= rd_line_n;
         cmd_err       <= cmd_err | drop;
         ready_mem     <= ready_n;
         busy          <= busy_n;
         mem_req_valid <= req_valid_n;
         mem_req_we    <= req_we_n;
         mem_req_addr  <= req_addr_n;
         mem_req_wdata <= req_wdata_n;
         if (wr_acc) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++)
               evict_q[i] <= evict_line[i*WORD_WIDTH +: WORD_WIDTH];
         end
         if (rsp_take) refill_q[rs_cnt] <= mem_rsp_rdata;
      end
   end

   // Present the refill buffer as a flat line, word 0 in the LSBs.
   always_comb begin
      refill_line = '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++)
         refill_line[i*WORD_WIDTH +: WORD_WIDTH] = refill_q[i];
   end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: a queue-based model predicts every memory beat and
// every returned line, and a negedge monitor compares the DUT against it.
module tb_cache_mem_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned WW = 32;
   localparam int unsigned LW = 4;
   localparam int unsigned LB = LW * WW;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [WW-1:0] wdata;
   } req_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          read_en_mem = 1'b0, write_en_mem = 1'b0;
   logic [AW-1:0] miss_addr = '0, evict_addr = '0;
   logic [LB-1:0] evict_line = '0;
   logic [LB-1:0] refill_line;
   logic          ready_mem, busy, cmd_err;
   logic          mem_req_valid, mem_req_we;
   logic          mem_req_ready = 1'b1;
   logic [AW-1:0] mem_req_addr;
   logic [WW-1:0] mem_req_wdata;
   logic          mem_rsp_valid = 1'b0;
   logic [WW-1:0] mem_rsp_rdata = '0;

   req_t          exp_req[$];
   logic [LB-1:0] exp_line[$];
   logic [WW-1:0] rsp_q[$];
   logic [LB-1:0] last_exp = '0;

   int vectors = 0, miscompares = 0;
   int cyc = 0, ready_cnt = 0, t_ready = -1, t0 = 0;
   bit bp_mode = 1'b0, stray_req = 1'b0;
   int bp_idx = 0;
   logic [3:0] bp_pat = 4'b1001;

   cache_mem_bridge #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
      .miss_addr(miss_addr), .evict_addr(evict_addr), .evict_line(evict_line),
      .refill_line(refill_line), .ready_mem(ready_mem), .busy(busy), .cmd_err(cmd_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got %0d cycles, limit reached)", cyc);
      $fatal(1);
   end

   function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'hA000_0000 | a;
   endfunction

   function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
      return a & ~32'hF;
   endfunction

   task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a write-back produces LW write beats carrying the line words in order.
   task automatic exp_write(input logic [AW-1:0] a, input logic [LB-1:0] line);
      for (int i = 0; i < LW; i++)
         exp_req.push_back('{1'b1, line_base(a) + AW'(4 * i), line[i*WW +: WW]});
   endtask

   // Model: a refill produces LW read beats and one returned line of memory contents.
   task automatic exp_read(input logic [AW-1:0] a);
      logic [LB-1:0] l;
      for (int i = 0; i < LW; i++) begin
         exp_req.push_back('{1'b0, line_base(a) + AW'(4 * i), '0});
         l[i*WW +: WW] = mem_word(line_base(a) + AW'(4 * i));
      end
      exp_line.push_back(l);
      last_exp = l;
   endtask

   // Memory side: ready pattern and in-order read responses one cycle after each read beat.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         rsp_q.delete();
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = '0;
      end else begin
         mem_req_ready = bp_mode ? bp_pat[bp_idx % 4] : 1'b1;
         bp_idx++;
         if (rsp_q.size() != 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rsp_q.pop_front();
         end else if (stray_req) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h0000_DEAD;
            stray_req     = 1'b0;
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
         end
      end
   end

   // Monitor: beats against the model, request stability under backpressure, returned lines.
   logic          stall_q = 1'b0;
   req_t          stall_req;
   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", LB'(mem_req_valid), LB'(1));
            check("hold_req", LB'({mem_req_we, mem_req_addr, mem_req_wdata}), LB'(stall_req));
         end
         if (mem_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_req: got addr %h we %b expected no beat", mem_req_addr, mem_req_we);
            end else begin
               req_t e;
               e = exp_req.pop_front();
               check("req_we", LB'(mem_req_we), LB'(e.we));
               check("req_addr", LB'(mem_req_addr), LB'(e.addr));
               if (e.we) check("req_wdata", LB'(mem_req_wdata), LB'(e.wdata));
            end
            if (!mem_req_we) rsp_q.push_back(mem_word(mem_req_addr));
         end
         stall_q   = mem_req_valid && !mem_req_ready;
         stall_req = '{mem_req_we, mem_req_addr, mem_req_wdata};
         if (ready_mem) begin
            ready_cnt++;
            t_ready = cyc;
            if (exp_line.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ready: got ready_mem=1 expected 0");
            end else begin
               check("refill_line", refill_line, exp_line.pop_front());
            end
         end
      end
   end

   // Wait until the model has consumed every predicted beat and line and the DUT is idle.
   task automatic wait_quiet();
      int n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while ((exp_req.size() != 0 || exp_line.size() != 0 || busy) && n < 300);
      vectors++;
      if (n >= 300) begin
         miscompares++;
         $display("FAIL timeout: got %0d beats / %0d lines outstanding, busy=%b, expected none",
                  exp_req.size(), exp_line.size(), busy);
      end
   endtask

   task automatic pulse_read(input logic [AW-1:0] a);
      @(posedge clk); #1;
      miss_addr = a; read_en_mem = 1'b1; exp_read(a); t0 = cyc;
      @(posedge clk); #1;
      read_en_mem = 1'b0; miss_addr = 32'hFFFF_FFF0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", LB'({ready_mem, busy, cmd_err, mem_req_valid, mem_req_we}), LB'(0));
      check("reset_addr", LB'(mem_req_addr), LB'(0));
      check("reset_wdata", LB'(mem_req_wdata), LB'(0));
      check("reset_line", refill_line, LB'(0));
      #2 rst = 1'b0;

      // Clean refill with minimum latency
      pulse_read(32'h0000_1004);
      wait_quiet();
      check("clean_latency", LB'(t_ready - t0), LB'(6));
      check("clean_line", refill_line, {32'hA000_100C, 32'hA000_1008, 32'hA000_1004, 32'hA000_1000});

      // Dirty miss: write-back, read pulse one cycle later while the write burst runs
      @(posedge clk); #1;
      evict_addr = 32'h0000_2008;
      evict_line = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
      write_en_mem = 1'b1;
      exp_write(evict_addr, evict_line);
      @(posedge clk); #1;
      write_en_mem = 1'b0; evict_line = '1; evict_addr = 32'hFFFF_FFFF;
      miss_addr = 32'h0000_1000; read_en_mem = 1'b1; exp_read(miss_addr);
      @(posedge clk); #1;
      read_en_mem = 1'b0;
      wait_quiet();
      check("dirty_ready_cnt", LB'(ready_cnt), LB'(2));
      check("dirty_no_err", LB'(cmd_err), LB'(0));

      // Second write-back pulse during WB is dropped
      @(posedge clk); #1;
      evict_addr = 32'h0000_4000;
      evict_line = {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0};
      write_en_mem = 1'b1;
      exp_write(evict_addr, evict_line);
      @(posedge clk); #1;
      write_en_mem = 1'b0;
      @(posedge clk); #1;
      evict_addr = 32'h0000_5550; evict_line = {4{32'h5555_5555}}; write_en_mem = 1'b1;
      @(posedge clk); #1;
      write_en_mem = 1'b0;
      wait_quiet();
      check("wb_drop_err", LB'(cmd_err), LB'(1));

      // Second refill pulse during RD_WAIT is dropped
      pulse_read(32'h0000_3000);
      repeat (4) @(posedge clk);
      #1;
      miss_addr = 32'h0000_3330; read_en_mem = 1'b1;
      @(posedge clk); #1;
      read_en_mem = 1'b0;
      wait_quiet();
      check("rd_drop_err", LB'(cmd_err), LB'(1));
      check("rd_drop_ready_cnt", LB'(ready_cnt), LB'(3));

      // Backpressure 1,0,0,1 with write-back and refill in the same cycle
      @(posedge clk); #3;
      bp_mode = 1'b1;
      @(posedge clk); #1;
      evict_addr = 32'h0000_5000;
      evict_line = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
      miss_addr  = 32'h0000_6000;
      write_en_mem = 1'b1; read_en_mem = 1'b1;
      exp_write(evict_addr, evict_line);
      exp_read(miss_addr);
      @(posedge clk); #1;
      write_en_mem = 1'b0; read_en_mem = 1'b0;
      wait_quiet();
      #1 bp_mode = 1'b0;
      check("bp_ready_cnt", LB'(ready_cnt), LB'(4));
      check("bp_line", refill_line, {32'hA000_600C, 32'hA000_6008, 32'hA000_6004, 32'hA000_6000});
      check("err_sticky", LB'(cmd_err), LB'(1));

      // Stray response in IDLE
      @(posedge clk); #3;
      stray_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("stray_line", refill_line, last_exp);
      check("stray_ready_cnt", LB'(ready_cnt), LB'(4));
      check("stray_busy", LB'(busy), LB'(0));

      // Reset during beat 2 of a refill
      pulse_read(32'h0000_7000);
      repeat (2) @(posedge clk);
      #1;
      check("beat2_addr", LB'(mem_req_addr), LB'(32'h0000_7008));
      #1 rst = 1'b1;
      #1;
      check("rst_valid", LB'(mem_req_valid), LB'(0));
      check("rst_ctl", LB'({ready_mem, busy, cmd_err, mem_req_we}), LB'(0));
      check("rst_addr", LB'(mem_req_addr), LB'(0));
      check("rst_line", refill_line, LB'(0));
      exp_req.delete();
      exp_line.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_ready_cnt", LB'(ready_cnt), LB'(4));

      // Refill after reset succeeds
      pulse_read(32'h0000_8000);
      wait_quiet();
      check("post_rst_line", refill_line, {32'hA000_800C, 32'hA000_8008, 32'hA000_8004, 32'hA000_8000});
      check("final_ready_cnt", LB'(ready_cnt), LB'(5));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
